// File: rtl/control_sequencer_pkg.sv
// Purpose : shared constants for the 8-bit bus computer control unit.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: opcode values, T-state indices, control-word bit indices and masks.
package control_sequencer_pkg;

  localparam int NUM_STEPS_DEF = 5;
  localparam int OPW_DEF       = 4;
  localparam int CTRL_W        = 16;
  // $clog2(NUM_STEPS_DEF); also the width of the t_state debug port
  localparam int STEP_W        = 3;

  typedef logic [CTRL_W-1:0] ctrl_word_t;
  typedef logic [STEP_W-1:0] step_t;

  localparam step_t T0 = 3'd0;
  localparam step_t T1 = 3'd1;
  localparam step_t T2 = 3'd2;
  localparam step_t T3 = 3'd3;
  localparam step_t T4 = 3'd4;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  localparam ctrl_word_t C_HLT = ctrl_word_t'(1) << B_HLT;
  localparam ctrl_word_t C_MI  = ctrl_word_t'(1) << B_MI;
  localparam ctrl_word_t C_RI  = ctrl_word_t'(1) << B_RI;
  localparam ctrl_word_t C_RO  = ctrl_word_t'(1) << B_RO;
  localparam ctrl_word_t C_IO  = ctrl_word_t'(1) << B_IO;
  localparam ctrl_word_t C_II  = ctrl_word_t'(1) << B_II;
  localparam ctrl_word_t C_AI  = ctrl_word_t'(1) << B_AI;
  localparam ctrl_word_t C_AO  = ctrl_word_t'(1) << B_AO;
  localparam ctrl_word_t C_EO  = ctrl_word_t'(1) << B_EO;
  localparam ctrl_word_t C_SU  = ctrl_word_t'(1) << B_SU;
  localparam ctrl_word_t C_BI  = ctrl_word_t'(1) << B_BI;
  localparam ctrl_word_t C_OI  = ctrl_word_t'(1) << B_OI;
  localparam ctrl_word_t C_CE  = ctrl_word_t'(1) << B_CE;
  localparam ctrl_word_t C_CO  = ctrl_word_t'(1) << B_CO;
  localparam ctrl_word_t C_J   = ctrl_word_t'(1) << B_J;
  localparam ctrl_word_t C_FI  = ctrl_word_t'(1) << B_FI;

endpackage

// File: rtl/control_sequencer_if.sv
// Purpose : bundle between the instruction register/flags and the control unit.
// Latency : n/a (wires only).
// Backpressure: step_en is the only throttle; the sequencer holds its state while it is low.
// master = control unit (drives ctrl/t_state/halted); slave = IR, flags and datapath side.
interface control_sequencer_if #(
  parameter int OPW = 4
);
  import control_sequencer_pkg::*;

  logic             step_en;
  logic [OPW-1:0]   opcode;
  logic             flag_c;
  logic             flag_z;
  ctrl_word_t       ctrl;
  step_t            t_state;
  logic             halted;

  modport master (
    input  step_en, opcode, flag_c, flag_z,
    output ctrl, t_state, halted
  );

  modport slave (
    output step_en, opcode, flag_c, flag_z,
    input  ctrl, t_state, halted
  );

endinterface

// File: rtl/control_sequencer_microcode_rom.sv
// Purpose : combinational microcode: {opcode, step, flags} -> control word + last used step.
// Latency : zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: opcode/step/flag_c/flag_z in; ctrl out; last_step = final T-state used by this opcode.
module control_sequencer_microcode_rom
  import control_sequencer_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic [OPW-1:0] opcode,
  input  step_t          step,
  input  logic           flag_c,
  input  logic           flag_z,
  output ctrl_word_t     ctrl,
  output step_t          last_step
);

  ctrl_word_t ex2, ex3, ex4;

  always_comb begin
    ex2       = '0;
    ex3       = '0;
    ex4       = '0;
    // Unknown opcodes fall through as NOP: fetch only, end at T1.
    last_step = T1;
    case (opcode)
      OPW'(OP_LDA): begin ex2 = C_IO | C_MI; ex3 = C_RO | C_AI; last_step = T3; end
      OPW'(OP_ADD): begin
        ex2 = C_IO | C_MI; ex3 = C_RO | C_BI; ex4 = C_EO | C_AI | C_FI; last_step = T4;
      end
      OPW'(OP_SUB): begin
        ex2 = C_IO | C_MI; ex3 = C_RO | C_BI; ex4 = C_EO | C_AI | C_SU | C_FI; last_step = T4;
      end
      OPW'(OP_STA): begin ex2 = C_IO | C_MI; ex3 = C_AO | C_RI; last_step = T3; end
      OPW'(OP_LDI): begin ex2 = C_IO | C_AI; last_step = T2; end
      OPW'(OP_JMP): begin ex2 = C_IO | C_J;  last_step = T2; end
      // Conditional jumps end at T2 whether taken or not, so timing is flag-independent.
      OPW'(OP_JC):  begin ex2 = flag_c ? (C_IO | C_J) : '0; last_step = T2; end
      OPW'(OP_JZ):  begin ex2 = flag_z ? (C_IO | C_J) : '0; last_step = T2; end
      OPW'(OP_OUT): begin ex2 = C_AO | C_OI; last_step = T2; end
      OPW'(OP_HLT): begin ex2 = C_HLT; last_step = T2; end
      default: ;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (step)
      T0:      ctrl = C_CO | C_MI;
      T1:      ctrl = C_RO | C_II | C_CE;
      T2:      ctrl = ex2;
      T3:      ctrl = ex3;
      T4:      ctrl = ex4;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Purpose : T-state step counter, halt latch and microcode decode for the 8-bit bus computer.
// Latency : ctrl is combinational from the current step; step advances one per enabled clock.
// Backpressure: step_en=0 freezes t_state and ctrl; once halted, step_en is ignored until reset.
// Ports: clock, reset_btn (async active-low), bus (master: step_en/opcode/flags in, ctrl/t_state/halted out).
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter bit EARLY_END = 1'b1,
  parameter int OPW       = OPW_DEF
) (
  input  logic                  clock,
  input  logic                  reset_btn,
  control_sequencer_if.master   bus
);

  localparam step_t FULL_LAST = step_t'(NUM_STEPS - 1);

  step_t      step_q;
  logic       halted_q;
  ctrl_word_t rom_ctrl;
  step_t      rom_last;
  step_t      last_step;
  logic       hlt_now;

  control_sequencer_microcode_rom #(
    .OPW (OPW)
  ) u_rom (
    .opcode    (bus.opcode),
    .step      (step_q),
    .flag_c    (bus.flag_c),
    .flag_z    (bus.flag_z),
    .ctrl      (rom_ctrl),
    .last_step (rom_last)
  );

  assign last_step = EARLY_END ? rom_last : FULL_LAST;
  assign hlt_now   = (step_q == T2) && (bus.opcode == OPW'(OP_HLT));

  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else if (!halted_q && bus.step_en) begin
      if (hlt_now) begin
        // Park in T2 rather than wrapping, so the LEDs show where execution stopped.
        halted_q <= 1'b1;
      end else if (step_q == last_step) begin
        step_q <= T0;
      end else begin
        step_q <= step_q + step_t'(1);
      end
    end
  end

  // Once halted the opcode may change underneath us; force the word rather than trust the ROM.
  assign bus.ctrl    = halted_q ? C_HLT : rom_ctrl;
  assign bus.t_state = step_q;
  assign bus.halted  = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic clock;
  logic reset_btn;
  int   n_cmp;
  int   n_bad;

  control_sequencer_if #(.OPW(4)) b1 ();
  control_sequencer_if #(.OPW(4)) b0 ();

  control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b1), .OPW(4)) dut_early (
    .clock     (clock),
    .reset_btn (reset_btn),
    .bus       (b1.master)
  );

  control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b0), .OPW(4)) dut_full (
    .clock     (clock),
    .reset_btn (reset_btn),
    .bus       (b0.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect1(input string tag, input logic [15:0] c, input logic [2:0] t, input logic h);
    check({tag, ".ctrl"}, b1.ctrl, c);
    check({tag, ".t"}, {13'd0, b1.t_state}, {13'd0, t});
    check({tag, ".halt"}, {15'd0, b1.halted}, {15'd0, h});
  endtask

  task automatic expect0(input string tag, input logic [15:0] c, input logic [2:0] t);
    check({tag, ".ctrl"}, b0.ctrl, c);
    check({tag, ".t"}, {13'd0, b0.t_state}, {13'd0, t});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_btn  = 1'b0;
    b1.step_en = 1'b0; b1.opcode = 4'h0; b1.flag_c = 1'b0; b1.flag_z = 1'b0;
    b0.step_en = 1'b0; b0.opcode = 4'h0; b0.flag_c = 1'b0; b0.flag_z = 1'b0;
    #3;
    expect1("rst", 16'h4004, 3'd0, 1'b0);
    expect0("rst_full", 16'h4004, 3'd0);
    tick();
    tick();
    reset_btn = 1'b1;

    // Reset in the middle of LDA T3
    b1.opcode = 4'b0001; b1.step_en = 1'b1;
    tick(); expect1("lda.t1", 16'h1408, 3'd1, 1'b0);
    tick(); expect1("lda.t2", 16'h4800, 3'd2, 1'b0);
    tick(); expect1("lda.t3", 16'h1200, 3'd3, 1'b0);
    reset_btn = 1'b0;
    #1; expect1("midrst", 16'h4004, 3'd0, 1'b0);
    tick(); expect1("midrst.hold", 16'h4004, 3'd0, 1'b0);
    reset_btn = 1'b1;

    // ADD full sequence
    b1.opcode = 4'b0010;
    expect1("add.t0", 16'h4004, 3'd0, 1'b0);
    tick(); expect1("add.t1", 16'h1408, 3'd1, 1'b0);
    tick(); expect1("add.t2", 16'h4800, 3'd2, 1'b0);
    tick(); expect1("add.t3", 16'h1020, 3'd3, 1'b0);
    tick(); expect1("add.t4", 16'h0281, 3'd4, 1'b0);
    tick(); expect1("add.end", 16'h4004, 3'd0, 1'b0);

    // JC taken / not taken
    b1.opcode = 4'b0111; b1.flag_c = 1'b1;
    tick(); tick(); expect1("jc1.t2", 16'h0802, 3'd2, 1'b0);
    tick(); expect1("jc1.end", 16'h4004, 3'd0, 1'b0);
    b1.flag_c = 1'b0;
    tick(); tick(); expect1("jc0.t2", 16'h0000, 3'd2, 1'b0);
    tick(); expect1("jc0.end", 16'h4004, 3'd0, 1'b0);

    // JZ taken, then SUB through T4 with a flag change after T2
    b1.opcode = 4'b1000; b1.flag_z = 1'b1;
    tick(); tick(); expect1("jz1.t2", 16'h0802, 3'd2, 1'b0);
    tick(); b1.opcode = 4'b0011;
    tick(); tick(); expect1("sub.t2", 16'h4800, 3'd2, 1'b0);
    b1.flag_z = 1'b0; b1.flag_c = 1'b1;
    tick(); expect1("sub.t3", 16'h1020, 3'd3, 1'b0);
    tick(); expect1("sub.t4", 16'h02C1, 3'd4, 1'b0);
    tick(); expect1("sub.end", 16'h4004, 3'd0, 1'b0);
    b1.flag_c = 1'b0;

    // STA ends at T3, OUT at T2
    b1.opcode = 4'b0100;
    tick(); tick(); tick(); expect1("sta.t3", 16'h2100, 3'd3, 1'b0);
    tick(); expect1("sta.end", 16'h4004, 3'd0, 1'b0);
    b1.opcode = 4'b1110;
    tick(); tick(); expect1("out.t2", 16'h0110, 3'd2, 1'b0);
    tick(); expect1("out.end", 16'h4004, 3'd0, 1'b0);

    // step_en stall in T1 (LDI)
    b1.opcode = 4'b0101;
    tick(); expect1("ldi.t1", 16'h1408, 3'd1, 1'b0);
    b1.step_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect1("stall", 16'h1408, 3'd1, 1'b0);
    end
    b1.step_en = 1'b1;
    tick(); expect1("ldi.t2", 16'h0A00, 3'd2, 1'b0);
    tick(); expect1("ldi.end", 16'h4004, 3'd0, 1'b0);

    // HLT
    b1.opcode = 4'b1111;
    tick(); tick(); expect1("hlt.t2", 16'h8000, 3'd2, 1'b0);
    tick(); expect1("hlt.latched", 16'h8000, 3'd2, 1'b1);
    b1.opcode = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      b1.step_en = i[0];
      tick();
    end
    expect1("hlt.frozen", 16'h8000, 3'd2, 1'b1);
    reset_btn = 1'b0;
    #1; expect1("hlt.rst", 16'h4004, 3'd0, 1'b0);
    tick();
    reset_btn = 1'b1;

    // NOP: full-length versus early-end instances side by side
    b1.opcode = 4'b0000; b1.step_en = 1'b1;
    b0.opcode = 4'b0000; b0.step_en = 1'b1;
    tick();
    expect0("nopf.t1", 16'h1408, 3'd1);
    expect1("nope.t1", 16'h1408, 3'd1, 1'b0);
    tick();
    expect0("nopf.t2", 16'h0000, 3'd2);
    expect1("nope.end", 16'h4004, 3'd0, 1'b0);
    tick(); expect0("nopf.t3", 16'h0000, 3'd3);
    tick(); expect0("nopf.t4", 16'h0000, 3'd4);
    tick(); expect0("nopf.end", 16'h4004, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
